// File: rtl/mult4_share_arb.sv
// Round-robin sharing of one 4x4 multiplier core between N_REQ requesters,
// with a two-stage pipeline. Optional per-requester grant counters: MULT4_SHARE_STATS_EN.

module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = {4'b0000, x} * {4'b0000, y};
endmodule

module mult4_share_arb #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_x,
    input  logic [4*N_REQ-1:0]   req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
`ifdef MULT4_SHARE_STATS_EN
    output logic [7:0]           rsp_prod,
    output logic [8*N_REQ-1:0]   grant_cnt
`else
    output logic [7:0]           rsp_prod
`endif
);
    localparam logic [ID_W:0]   N_REQ_W  = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] rr_ptr;
    logic            s1_v, s2_v;
    logic [ID_W-1:0] s1_id, s2_id;
    logic [3:0]      s1_x, s1_y;
    logic [7:0]      s2_p;
    logic [7:0]      core_o;

    logic            s1_load, s2_load, grant_ok, found, grant;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] gnt_idx;
    logic [3:0]      gnt_x, gnt_y;

    main u_core (.x(s1_x), .y(s1_y), .o(core_o));

    assign s2_load  = s1_v & (~s2_v | rsp_ready);
    assign s1_load  = ~s1_v | s2_load;
    assign grant_ok = s1_load & ~flush & ~rst;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        found     = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= N_REQ_W) idx = idx - N_REQ_W;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[ID_W-1:0];
            end
        end
        if (found && grant_ok) req_ready[gnt_idx] = 1'b1;
    end

    assign grant = found & grant_ok;
    assign gnt_x = req_x[{gnt_idx, 2'b00} +: 4];
    assign gnt_y = req_y[{gnt_idx, 2'b00} +: 4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            s1_v   <= 1'b0;
            s1_id  <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
            s2_v   <= 1'b0;
            s2_id  <= '0;
            s2_p   <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_v  <= 1'b1;
                s2_id <= s1_id;
                s2_p  <= core_o;
            end else if (rsp_ready) begin
                s2_v <= 1'b0;
            end
            if (grant) begin
                s1_v   <= 1'b1;
                s1_id  <= gnt_idx;
                s1_x   <= gnt_x;
                s1_y   <= gnt_y;
                rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end
        end
    end

    assign rsp_valid = s2_v;
    assign rsp_id    = s2_id;
    assign rsp_prod  = s2_p;

`ifdef MULT4_SHARE_STATS_EN
    // Saturating accepted-request counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grant_cnt[8*i +: 8] != 8'hFF)
                    grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult4_share_arb.sv
// Self-checking bench for mult4_share_arb (N_REQ=4): vector table, scoreboard,
// fairness sweep, backpressure, flush/reset; counters when MULT4_SHARE_STATS_EN is set.

module tb_mult4_share_arb;
    logic        clk, rst, flush, rsp_valid, rsp_ready;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_x, req_y;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_prod;
`ifdef MULT4_SHARE_STATS_EN
    logic [31:0] grant_cnt;
`endif

    logic [3:0] ox [4];
    logic [3:0] oy [4];

    typedef struct {
        logic [1:0] id;
        logic [7:0] prod;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [1:0] id;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] prod;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    mult4_share_arb #(.N_REQ(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
`ifdef MULT4_SHARE_STATS_EN
        .rsp_prod(rsp_prod),
        .grant_cnt(grant_cnt)
`else
        .rsp_prod(rsp_prod)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < 4; i++) begin
            req_x[4*i +: 4] = ox[i];
            req_y[4*i +: 4] = oy[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs sampled on the falling edge; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted request, pop on delivered response.
    logic       hold_pend = 1'b0;
    logic [1:0] hold_id;
    logic [7:0] hold_prod;
    always @(negedge clk) begin
        if (hold_pend && rsp_valid) begin
            check("hold_id", 32'(rsp_id), 32'(hold_id));
            check("hold_prod", 32'(rsp_prod), 32'(hold_prod));
        end
        hold_pend = rsp_valid && !rsp_ready && !rst && !flush;
        hold_id   = rsp_id;
        hold_prod = rsp_prod;
        if (rst) begin
            sb.delete();
        end else begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("sb_id", 32'(rsp_id), 32'(e.id));
                    check("sb_prod", 32'(rsp_prod), 32'(e.prod));
                end
            end
            if (flush) sb.delete();
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_t n;
                    n.id   = 2'(i);
                    n.prod = {4'b0, ox[i]} * {4'b0, oy[i]};
                    sb.push_back(n);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check("ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic refresh(input logic [3:0] acc);
        for (int i = 0; i < 4; i++)
            if (acc[i]) begin
                ox[i] = 4'($urandom_range(0, 15));
                oy[i] = 4'($urandom_range(0, 15));
            end
    endtask

    vec_t vecs[8];
    logic [3:0] acc;
    int accepts, sweep, cyc, exp_id, grants;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ox[i] = '0;
            oy[i] = '0;
        end
        vecs[0] = '{2'd2, 4'd13, 4'd11, 8'd143};
        vecs[1] = '{2'd0, 4'd15, 4'd15, 8'd225};
        vecs[2] = '{2'd1, 4'd0,  4'd9,  8'd0};
        vecs[3] = '{2'd0, 4'd15, 4'd1,  8'd15};
        vecs[4] = '{2'd1, 4'd8,  4'd8,  8'd64};
        vecs[5] = '{2'd2, 4'd9,  4'd0,  8'd0};
        vecs[6] = '{2'd3, 4'd7,  4'd9,  8'd63};
        vecs[7] = '{2'd3, 4'd12, 4'd14, 8'd168};

        do_reset();
        @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_prod", 32'(rsp_prod), 32'd0);

        // Single requests: accept in first cycle, response after one more edge.
        foreach (vecs[v]) begin
            tick();
            ox[vecs[v].id] = vecs[v].x;
            oy[vecs[v].id] = vecs[v].y;
            req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            check("single_accept", 32'(req_ready), 32'(1 << vecs[v].id));
            tick();
            req_valid = '0;
            @(negedge clk);
            check("single_early", 32'(rsp_valid), 32'd0);
            tick();
            @(negedge clk);
            check("single_valid", 32'(rsp_valid), 32'd1);
            check("single_id", 32'(rsp_id), 32'(vecs[v].id));
            check("single_prod", 32'(rsp_prod), 32'(vecs[v].prod));
        end

        // Last grant went to requester 3: pointer must have wrapped to 0.
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("rr_wrap", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_drain();

        // Fairness with full operand sweep on requester 0.
        do_reset();
        rsp_ready = 1'b1;
        refresh(4'hF);
        ox[0] = 4'd0;
        oy[0] = 4'd0;
        sweep = 0;
        cyc = 0;
        exp_id = 0;
        req_valid = 4'hF;
        while (sweep < 256 && cyc < 1200) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            check("fair_grant", 32'(acc), 32'(1 << exp_id));
            if (cyc >= 2) check("fair_rsp_each_cycle", 32'(rsp_valid), 32'd1);
            exp_id = (exp_id + 1) % 4;
            cyc++;
            tick();
            refresh(acc & 4'b1110);
            if (acc[0]) begin
                sweep++;
                ox[0] = 4'(sweep / 16);
                oy[0] = 4'(sweep % 16);
            end
        end
        check("fair_sweep_done", 32'(sweep), 32'd256);
        req_valid = '0;
        wait_drain();

        // Backpressure: two accepts, then stall; drain in grant order.
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            accepts += $countones(acc);
            if (c == 4) check("bp_ready_low", 32'(req_ready), 32'd0);
            tick();
            refresh(acc);
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        check("bp_valid_held", 32'(rsp_valid), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain();

        // Flush with two in flight; rr_ptr must survive the flush.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(req_ready), 32'd0);
        check("flush_inflight", 32'(rsp_valid), 32'd1);
        tick();
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("flush_rr_kept", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        wait_drain();

        // Reset asserted together with flush, with two in flight.
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        flush = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rstflush_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rstflush_valid", 32'(rsp_valid), 32'd0);
        check("rstflush_id", 32'(rsp_id), 32'd0);
        check("rstflush_prod", 32'(rsp_prod), 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("rstflush_rr0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain();

`ifdef MULT4_SHARE_STATS_EN
        // Counter saturation, flush immunity, reset clear.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        grants = 0;
        cyc = 0;
        while (grants < 300 && cyc < 400) begin
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) grants++;
            cyc++;
            tick();
            refresh(4'b0010);
        end
        req_valid = '0;
        @(negedge clk);
        check("stats_grants", 32'(grants), 32'd300);
        check("stats_sat", 32'(grant_cnt[15:8]), 32'd255);
        check("stats_other", 32'(grant_cnt[7:0]), 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("stats_flush", 32'(grant_cnt[15:8]), 32'd255);
        do_reset();
        @(negedge clk);
        check("stats_rst", grant_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult4_share_arb.md
# mult4_share_arb

Round-robin arbiter and two-stage pipeline controller that shares one 4x4 combinational multiplier core (module `main`, ports `x[3:0]`, `y[3:0]`, `o[7:0]`) between N requesters. Each requester presents an operand pair on a valid/ready port. The block grants at most one request per cycle, registers the operands in front of the core, and registers the product behind it. Results return on a single valid/ready response port, tagged with the requester index.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester-ID width; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline clear.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_x`  in  4*N_REQ  multiplicand; requester i uses bits [4i+3:4i].
- `req_y`  in  4*N_REQ  multiplier; same packing as `req_x`.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_prod`.
- `rsp_prod`  out  8  unsigned product x*y.
- `grant_cnt`  out  8*N_REQ  per-requester accepted-request counters; present only with `MULT4_SHARE_STATS_EN`.

## Operation
- Requester i transfers when `req_valid[i] & req_ready[i]` is high at a rising edge. The requester holds valid and operands stable until that edge.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and pipeline state.
- Arbitration:
  - `rr_ptr` (ID_W bits) marks the highest-priority requester.
  - Priority is searched from `rr_ptr` upward, wrapping modulo N_REQ.
  - The first valid requester found is granted, and only if stage S1 can load.
  - On a grant to requester i, `rr_ptr` <= (i+1) mod N_REQ.
  - With no grant, `rr_ptr` holds.
- Stage S1 registers: `s1_v`, `s1_id`, `s1_x`, `s1_y`. `s1_x` and `s1_y` drive the multiplier core directly.
- Stage S2 registers: `s2_v`, `s2_id`, `s2_p` (the core's `o`). S2 drives `rsp_valid`, `rsp_id`, `rsp_prod`.
- Advance rules:
  - `s2_load = s1_v & (!s2_v | rsp_ready)`.
  - `s1_load = !s1_v | s2_load`.
  - Grant is permitted only when `s1_load & !flush`.
- Bubbles: when S1 advances to S2 and no new grant occurs, `s1_v` <= 0. When S2 drains (`rsp_ready`) with no `s2_load`, `s2_v` <= 0.
- Flush:
  - `flush` high forces `s1_v`, `s2_v` <= 0 at the next edge.
  - All `req_ready` are 0 during the flush cycle.
  - `rr_ptr` and the counters are unchanged.
  - A response handshaken in the same cycle still counts as delivered.
- Reset: `rst` overrides `flush` and all traffic.
  - `rr_ptr` = 0, `s1_v` = `s2_v` = 0, and all data registers = 0.
  - Outputs after reset: `rsp_valid` = 0, `rsp_id` = 0, `rsp_prod` = 0.
  - `req_ready` = 0 while `rst` is high.
  - In-flight requests are dropped silently.
- Product arithmetic: unsigned, 8 bits, with no truncation (15*15 = 225).

## Timing
- Latency: a request accepted at edge k gives `rsp_valid` = 1 after edge k+1 (S1 loads at k, S2 loads at k+1), with no backpressure.
- Throughput: one result per cycle with `rsp_ready` held high.
- Backpressure with `rsp_ready` = 0:
  - S2 holds.
  - S1 fills once more, then `req_ready` = 0.
  - Maximum 2 requests in flight.
- The response payload is stable while `rsp_valid & !rsp_ready`.
- No combinational path from `rsp_ready` to `rsp_valid`/`rsp_prod`. A path from `rsp_ready` to `req_ready` is permitted.

## Configuration
- `MULT4_SHARE_STATS_EN` defined:
  - Adds `grant_cnt`: one 8-bit counter per requester.
  - The counter increments on each accepted request and saturates at 255.
  - Counters clear on `rst`; `flush` does not clear them.
- Not defined: no `grant_cnt` port, no counter logic. Behaviour is otherwise identical.

## Test plan
- Single request: after reset, requester 2 presents x=13, y=11 -> accepted in its first cycle; `rsp_valid` one cycle later with `rsp_prod`=143, `rsp_id`=2.
- Fairness: all 4 requesters valid continuously, `rsp_ready`=1 -> grants in order 0,1,2,3,0,… with one response per cycle. Products match x*y for all 16x16 operand pairs swept on requester 0.
- Backpressure: `rsp_ready`=0 for 5 cycles with continuous requests -> exactly 2 accepts, then `req_ready`=0. Payload is held stable. On release, responses drain in grant order with no loss or duplication.
- Boundary: x=15, y=15 -> 225; x=0, y=9 -> 0. `rr_ptr` wraps from 3 to 0 after a grant to requester 3.
- Flush/reset mid-operation: with 2 in flight, assert `flush` -> `rsp_valid`=0 next cycle and no response for the flushed requests. Assert `rst` while `flush` is high -> reset values, and `rr_ptr`=0 after reset.
- Stats (macro on): 300 grants to requester 1 -> `grant_cnt[15:8]`=255. Counters are unchanged by `flush` and cleared by `rst`.
